s_axi_regfile_burst: RTL and testbench

Parametrised AXI4 slave register file, successor to the fixed 8×32 single-beat register block. Adds configurable data width, register count and ID width, INCR bursts on both channels, byte strobes, and OKAY/SLVERR responses. Exposes the full register array to downstream logic, such as counter control, through a flat output bus. One outstanding write and one outstanding read; the write and read paths operate concurrently.

---
 rtl/s_axi_regfile_burst.sv | 191 +++++++++++++++++++
 tb/tb_s_axi_regfile_burst.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_axi_regfile_burst.sv
// rtl/s_axi_regfile_burst.sv - AXI4 slave register file with INCR bursts, byte strobes and SLVERR
module s_axi_regfile_burst #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 16,
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                        clk,
    input  logic                        areset,
    input  logic [ID_W-1:0]             awid_i,
    input  logic [ADDR_W-1:0]           awaddr_i,
    input  logic [7:0]                  awlen_i,
    input  logic                        awvalid_i,
    output logic                        awready_o,
    input  logic [DATA_W-1:0]           wdata_i,
    input  logic [DATA_W/8-1:0]         wstrb_i,
    input  logic                        wlast_i,
    input  logic                        wvalid_i,
    output logic                        wready_o,
    output logic [ID_W-1:0]             bid_o,
    output logic [1:0]                  bresp_o,
    output logic                        bvalid_o,
    input  logic                        bready_i,
    input  logic [ID_W-1:0]             arid_i,
    input  logic [ADDR_W-1:0]           araddr_i,
    input  logic [7:0]                  arlen_i,
    input  logic                        arvalid_i,
    output logic                        arready_o,
    output logic [ID_W-1:0]             rid_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic [1:0]                  rresp_o,
    output logic                        rlast_o,
    output logic                        rvalid_o,
    input  logic                        rready_i,
    output logic [REG_COUNT*DATA_W-1:0] regs_o
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(REG_COUNT);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(REG_COUNT);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_W-1:0] regs [REG_COUNT];

    w_state_t          w_state;
    logic [ADDR_W-1:0] w_idx;
    logic [7:0]        w_cnt;
    logic [7:0]        w_len;
    logic              w_err;
    logic              w_in_range;
    logic              w_final;
    logic              w_beat_err;

    r_state_t          r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [7:0]        r_cnt;
    logic [7:0]        r_len;
    logic [ADDR_W-1:0] r_sel_idx;
    logic              r_sel_ok;
    logic [DATA_W-1:0] r_sel_data;

    for (genvar i = 0; i < REG_COUNT; i++) begin : g_flat
        assign regs_o[i*DATA_W +: DATA_W] = regs[i];
    end

    always_comb begin
        w_in_range = w_idx < LIMIT;
        w_final    = w_cnt == w_len;
        w_beat_err = !w_in_range || (wlast_i != w_final);
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            w_state   <= W_IDLE;
            awready_o <= 1'b0;
            wready_o  <= 1'b0;
            bvalid_o  <= 1'b0;
            bresp_o   <= OKAY;
            bid_o     <= '0;
            w_idx     <= '0;
            w_cnt     <= '0;
            w_len     <= '0;
            w_err     <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready_o <= 1'b1;
                    if (awvalid_i && awready_o) begin
                        awready_o <= 1'b0;
                        wready_o  <= 1'b1;
                        bid_o     <= awid_i;
                        w_idx     <= awaddr_i >> OFF_W;
                        w_len     <= awlen_i;
                        w_cnt     <= '0;
                        w_err     <= 1'b0;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid_i && wready_o) begin
                        if (w_in_range) begin
                            for (int b = 0; b < STRB_W; b++)
                                if (wstrb_i[b]) regs[w_idx[IDX_W-1:0]][b*8 +: 8] <= wdata_i[b*8 +: 8];
                        end
                        w_err <= w_err | w_beat_err;
                        w_cnt <= w_cnt + 8'd1;
                        w_idx <= w_idx + ADDR_W'(1);
                        // An early wlast only flags an error; awlen alone decides the burst end.
                        if (w_final) begin
                            wready_o <= 1'b0;
                            bvalid_o <= 1'b1;
                            bresp_o  <= (w_err | w_beat_err) ? SLVERR : OKAY;
                            w_state  <= W_RESP;
                        end
                    end
                end
                default: begin
                    if (bready_i) begin
                        bvalid_o  <= 1'b0;
                        bresp_o   <= OKAY;
                        awready_o <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Beat to fetch next: the first beat from AR, otherwise the one after the presented beat.
    always_comb begin
        r_sel_idx  = (r_state == R_IDLE) ? (araddr_i >> OFF_W) : (r_idx + ADDR_W'(1));
        r_sel_ok   = r_sel_idx < LIMIT;
        r_sel_data = r_sel_ok ? regs[r_sel_idx[IDX_W-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            r_state   <= R_IDLE;
            arready_o <= 1'b0;
            rvalid_o  <= 1'b0;
            rdata_o   <= '0;
            rresp_o   <= OKAY;
            rlast_o   <= 1'b0;
            rid_o     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_len     <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready_o <= 1'b1;
                    if (arvalid_i && arready_o) begin
                        arready_o <= 1'b0;
                        rid_o     <= arid_i;
                        r_len     <= arlen_i;
                        r_cnt     <= '0;
                        r_idx     <= r_sel_idx;
                        rvalid_o  <= 1'b1;
                        rdata_o   <= r_sel_data;
                        rresp_o   <= r_sel_ok ? OKAY : SLVERR;
                        rlast_o   <= arlen_i == 8'd0;
                        r_state   <= R_DATA;
                    end
                end
                default: begin
                    if (rready_i) begin
                        if (rlast_o) begin
                            rvalid_o  <= 1'b0;
                            rlast_o   <= 1'b0;
                            rresp_o   <= OKAY;
                            rdata_o   <= '0;
                            arready_o <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_idx   <= r_sel_idx;
                            r_cnt   <= r_cnt + 8'd1;
                            rdata_o <= r_sel_data;
                            rresp_o <= r_sel_ok ? OKAY : SLVERR;
                            rlast_o <= (r_cnt + 8'd1) == r_len;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_s_axi_regfile_burst.sv
// tb/tb_s_axi_regfile_burst.sv - randomized scoreboard bench for s_axi_regfile_burst
module tb_s_axi_regfile_burst;
    localparam int DW = 32;
    localparam int RC = 16;
    localparam int IW = 4;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              areset = 1'b1;
    logic [IW-1:0]     awid_i = '0;
    logic [AW-1:0]     awaddr_i = '0;
    logic [7:0]        awlen_i = '0;
    logic              awvalid_i = 1'b0;
    logic              awready_o;
    logic [DW-1:0]     wdata_i = '0;
    logic [DW/8-1:0]   wstrb_i = '0;
    logic              wlast_i = 1'b0;
    logic              wvalid_i = 1'b0;
    logic              wready_o;
    logic [IW-1:0]     bid_o;
    logic [1:0]        bresp_o;
    logic              bvalid_o;
    logic              bready_i = 1'b0;
    logic [IW-1:0]     arid_i = '0;
    logic [AW-1:0]     araddr_i = '0;
    logic [7:0]        arlen_i = '0;
    logic              arvalid_i = 1'b0;
    logic              arready_o;
    logic [IW-1:0]     rid_o;
    logic [DW-1:0]     rdata_o;
    logic [1:0]        rresp_o;
    logic              rlast_o;
    logic              rvalid_o;
    logic              rready_i = 1'b0;
    logic [RC*DW-1:0]  regs_o;

    s_axi_regfile_burst #(.DATA_W(DW), .REG_COUNT(RC), .ID_W(IW), .ADDR_W(AW)) dut (
        .clk(clk), .areset(areset),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o), .rvalid_o(rvalid_o),
        .rready_i(rready_i), .regs_o(regs_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_exp_t;
    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } r_exp_t;

    b_exp_t        b_q[$];
    r_exp_t        r_q[$];
    logic [DW-1:0] model [RC];
    int            tests = 0;
    int            fails = 0;
    bit            rmode = 1'b0;
    bit            chk_aw = 1'b0;
    bit            chk_ar = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string name);
        logic [RC*DW-1:0] exp;
        for (int i = 0; i < RC; i++) exp[i*DW +: DW] = model[i];
        tests++;
        if (regs_o !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, regs_o, exp);
        end
    endtask

    // Background ready generation: random, or strict 1,0,1,0 toggling of rready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            bready_i = ($urandom_range(0, 3) != 0);
            if (rmode) rready_i = ~rready_i;
            else       rready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares every presented B/R against the scoreboard front.
    initial begin
        b_exp_t be;
        r_exp_t re;
        forever begin
            @(negedge clk);
            if (areset) begin
                chk_aw = 1'b0;
                chk_ar = 1'b0;
                continue;
            end
            if (chk_aw) begin
                check("awready_after_b", 64'(awready_o), 64'd1);
                chk_aw = 1'b0;
            end
            if (chk_ar) begin
                check("rvalid_after_rlast", 64'(rvalid_o), 64'd0);
                check("arready_after_rlast", 64'(arready_o), 64'd1);
                chk_ar = 1'b0;
            end
            if (bvalid_o && bready_i) begin
                if (b_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_b: got bid %h bresp %h expected none", bid_o, bresp_o);
                end else begin
                    be = b_q.pop_front();
                    check("bid", 64'(bid_o), 64'(be.id));
                    check("bresp", 64'(bresp_o), 64'(be.resp));
                    chk_aw = 1'b1;
                end
            end
            if (rvalid_o) begin
                if (r_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_r: got rdata %h expected none", rdata_o);
                end else begin
                    re = r_q[0];
                    check("rid", 64'(rid_o), 64'(re.id));
                    check("rdata", 64'(rdata_o), 64'(re.data));
                    check("rresp", 64'(rresp_o), 64'(re.resp));
                    check("rlast", 64'(rlast_o), 64'(re.last));
                    if (rready_i) begin
                        r_q.delete(0);
                        if (re.last) chk_ar = 1'b1;
                    end
                end
            end
        end
    end

    task automatic hs_wait(input int sel);
        int  n = 0;
        logic rdy;
        forever begin
            @(negedge clk);
            rdy = (sel == 0) ? awready_o : (sel == 1) ? wready_o : arready_o;
            if (rdy) break;
            n++;
            if (n > 200) begin
                tests++; fails++;
                $display("FAIL handshake_timeout: got no ready on channel %0d expected ready", sel);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d b and %0d r pending expected 0", b_q.size(), r_q.size());
            b_q.delete();
            r_q.delete();
        end
        #1;
    endtask

    // early >= 0 drives wlast on that beat as well as on the real last beat.
    task automatic write_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                               input int early, input bit fixed, input logic [DW-1:0] fdata,
                               input logic [DW/8-1:0] fstrb);
        logic [DW-1:0]   d [$];
        logic [DW/8-1:0] s [$];
        logic            l [$];
        bit              err = 1'b0;
        int              base = int'(addr >> 2);
        for (int b = 0; b <= len; b++) begin
            d.push_back(fixed ? fdata : DW'($urandom));
            s.push_back(fixed ? fstrb : (DW/8)'($urandom));
            l.push_back((b == len) || (b == early));
            if (l[b] != (b == len)) err = 1'b1;
            if (base + b < RC) begin
                for (int k = 0; k < DW/8; k++)
                    if (s[b][k]) model[base + b][k*8 +: 8] = d[b][k*8 +: 8];
            end else begin
                err = 1'b1;
            end
        end
        b_q.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
        awid_i = id; awaddr_i = addr; awlen_i = 8'(len); awvalid_i = 1'b1;
        hs_wait(0);
        awvalid_i = 1'b0;
        for (int b = 0; b <= len; b++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            wdata_i = d[b]; wstrb_i = s[b]; wlast_i = l[b]; wvalid_i = 1'b1;
            hs_wait(1);
            wvalid_i = 1'b0; wlast_i = 1'b0;
        end
        drain();
    endtask

    task automatic issue_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len);
        int base = int'(addr >> 2);
        for (int b = 0; b <= len; b++) begin
            if (base + b < RC) r_q.push_back('{id: id, data: model[base + b], resp: 2'b00, last: b == len});
            else               r_q.push_back('{id: id, data: '0, resp: 2'b10, last: b == len});
        end
        arid_i = id; araddr_i = addr; arlen_i = 8'(len); arvalid_i = 1'b1;
        hs_wait(2);
        arvalid_i = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < RC; i++) model[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_awready", 64'(awready_o), 64'd0);
        check("reset_arready", 64'(arready_o), 64'd0);
        check("reset_wready", 64'(wready_o), 64'd0);
        check("reset_bvalid", 64'(bvalid_o), 64'd0);
        check("reset_rvalid", 64'(rvalid_o), 64'd0);
        check("reset_rdata", 64'(rdata_o), 64'd0);
        check_regs("reset_regs");
        @(posedge clk);
        #1 areset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("awready_after_reset", 64'(awready_o), 64'd1);
        check("arready_after_reset", 64'(arready_o), 64'd1);
        @(posedge clk);
        #1;

        write_burst(4'd3, 32'h8, 0, -1, 1'b1, 32'hDEADBEEF, 4'hF);
        check("reg2_deadbeef", 64'(regs_o[2*DW +: DW]), 64'hDEADBEEF);
        check_regs("regs_single");

        write_burst(4'd1, 32'h0, 0, -1, 1'b1, 32'h11223344, 4'hF);
        write_burst(4'd1, 32'h0, 0, -1, 1'b1, 32'hAABBCCDD, 4'h5);
        check("reg0_strobe", 64'(regs_o[DW-1:0]), 64'h11BB33DD);

        write_burst(4'd2, 32'h38, 3, -1, 1'b0, '0, '0);
        check_regs("regs_top_cross");

        write_burst(4'd6, 32'h4, 2, 1, 1'b0, '0, '0);
        check_regs("regs_early_last");

        rmode = 1'b1;
        issue_read(4'd5, 32'h0, 3);
        drain();
        rmode = 1'b0;

        issue_read(4'd7, 32'h38, 3);
        drain();

        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] a;
            int            len;
            a   = AW'($urandom_range(0, RC + 3) * 4 + $urandom_range(0, 3));
            len = $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 0) begin
                write_burst(IW'($urandom), a, len,
                            ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1, 1'b0, '0, '0);
                check_regs("regs_random");
            end else begin
                issue_read(IW'($urandom), a, len);
                drain();
            end
        end

        // Reset while beat 2 of a read burst is presented.
        rmode = 1'b1;
        issue_read(4'd9, 32'h0, 3);
        n = 0;
        while (r_q.size() > 3 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("reset_burst_reached", 64'(r_q.size()), 64'd3);
        #1 areset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_q.delete();
        for (int i = 0; i < RC; i++) model[i] = '0;
        check("rvalid_reset_mid", 64'(rvalid_o), 64'd0);
        check("arready_reset_mid", 64'(arready_o), 64'd0);
        check_regs("regs_reset_mid");
        @(posedge clk);
        #1 areset = 1'b0;
        rmode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("arready_after_reset_mid", 64'(arready_o), 64'd1);
        check("rvalid_after_reset_mid", 64'(rvalid_o), 64'd0);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
